// File: rtl/mux_rr_arbiter_pkg.sv
// Shared encodings and defaults for the round-robin nibble-mux arbiter.
package mux_rr_arbiter_pkg;

    // State encoding doubles as the mux select: bit 0 = A granted, bit 1 = B granted.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2
    } state_e;

    localparam logic PTR_A = 1'b0;
    localparam logic PTR_B = 1'b1;

    localparam int HOLD_CYCLES_DEF = 50_000_000;
    localparam int CNT_W_DEF       = 26;

endpackage

// File: rtl/mux_rr_arbiter_sync.sv
// Two-flop synchronizer with a configurable reset value.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4-bit 2:1 nibble mux between switch banks A and B,
// with a bounded grant slice and a push-button forced hand-over.
import mux_rr_arbiter_pkg::*;

module mux_rr_arbiter #(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       CLOCK_50,
    input  logic       KEY1,
    input  logic [9:0] SW,
    input  logic       KEY0,
    output logic [9:0] LEDR
);

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(HOLD_CYCLES - 1);

    logic [9:0]       sw_s;
    logic             key_s;
    logic             key_prev_q;
    logic             press;
    logic             req_a;
    logic             req_b;
    logic             slice_end;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ptr_q, ptr_d;
    logic             grant_a_q;
    logic             grant_b_q;
    logic             out_en_q;
    logic [3:0]       data;

    sync_2ff #(.WIDTH(10), .RST_VAL(10'h000)) u_sync_sw (
        .clk_i  (CLOCK_50),
        .rst_ni (KEY1),
        .d_i    (SW),
        .q_o    (sw_s)
    );

    sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_key (
        .clk_i  (CLOCK_50),
        .rst_ni (KEY1),
        .d_i    (KEY0),
        .q_o    (key_s)
    );

    assign press     = key_prev_q & ~key_s;
    assign req_a     = sw_s[8];
    assign req_b     = sw_s[9];
    assign slice_end = (cnt_q == CNT_TC) | press;

    // Own-request drop is checked before slice end so it always wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req_a && (!req_b || ptr_q == PTR_B)) begin
                    state_d = ST_GNT_A;
                end else if (req_b) begin
                    state_d = ST_GNT_B;
                end
            end
            ST_GNT_A: begin
                if (!req_a) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ptr_d   = PTR_A;
                end else if (slice_end) begin
                    cnt_d = '0;
                    if (req_b) begin
                        state_d = ST_GNT_B;
                        ptr_d   = PTR_A;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GNT_B: begin
                if (!req_b) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ptr_d   = PTR_B;
                end else if (slice_end) begin
                    cnt_d = '0;
                    if (req_a) begin
                        state_d = ST_GNT_A;
                        ptr_d   = PTR_B;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // out_en_q blanks the whole LED bank while reset is held.
    always_ff @(posedge CLOCK_50) begin
        if (!KEY1) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ptr_q      <= PTR_B;
            grant_a_q  <= 1'b0;
            grant_b_q  <= 1'b0;
            key_prev_q <= 1'b1;
            out_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            grant_a_q  <= (state_d == ST_GNT_A);
            grant_b_q  <= (state_d == ST_GNT_B);
            key_prev_q <= key_s;
            out_en_q   <= 1'b1;
        end
    end

    always_comb begin
        data = 4'h0;
        unique case (state_q)
            ST_GNT_A: data = sw_s[3:0];
            ST_GNT_B: data = sw_s[7:4];
            default:  data = 4'h0;
        endcase
    end

    assign LEDR = out_en_q ? {grant_b_q, grant_a_q, 3'b000, ptr_q, data} : 10'h000;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus random traffic against a grant-ownership model.
module tb_mux_rr_arbiter;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       key1;
    logic       key0;
    logic [9:0] sw;
    logic [9:0] ledr;

    int total = 0;
    int bad   = 0;

    // Model: who owns the mux (0 none, 1 A, 2 B), cycles already used in the slice, last served.
    int         m_owner = 0;
    int         m_used  = 0;
    int         m_last  = 1;
    logic [9:0] m_s1 = '0, m_s2 = '0;
    logic       m_k1 = 1'b1, m_k2 = 1'b1, m_kprev = 1'b1;
    logic       m_on = 1'b0;

    mux_rr_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(3)) dut (
        .CLOCK_50 (clk),
        .KEY1     (key1),
        .SW       (sw),
        .KEY0     (key0),
        .LEDR     (ledr)
    );

    always #10 clk = ~clk;

    function automatic logic [9:0] exp_led();
        logic [3:0] d;
        d = (m_owner == 1) ? m_s2[3:0] : (m_owner == 2) ? m_s2[7:4] : 4'h0;
        if (!m_on) return 10'h000;
        return {(m_owner == 2), (m_owner == 1), 3'b000, m_last[0], d};
    endfunction

    // One rising edge: advance the model with the inputs present at that edge, then settle.
    task automatic tick();
        logic press, ra, rb, own, oth;
        @(posedge clk);
        if (!key1) begin
            m_owner = 0; m_used = 0; m_last = 1;
            m_s1 = '0; m_s2 = '0; m_k1 = 1'b1; m_k2 = 1'b1; m_kprev = 1'b1; m_on = 1'b0;
        end else begin
            press = m_kprev && !m_k2;
            ra = m_s2[8];
            rb = m_s2[9];
            if (m_owner == 0) begin
                m_used = 0;
                if (ra && rb)  m_owner = (m_last == 1) ? 1 : 2;
                else if (ra)   m_owner = 1;
                else if (rb)   m_owner = 2;
            end else begin
                own = (m_owner == 1) ? ra : rb;
                oth = (m_owner == 1) ? rb : ra;
                if (!own) begin
                    m_last = m_owner - 1; m_owner = 0; m_used = 0;
                end else if (m_used == HOLD - 1 || press) begin
                    if (oth) begin
                        m_last = m_owner - 1; m_owner = 3 - m_owner;
                    end
                    m_used = 0;
                end else begin
                    m_used++;
                end
            end
            m_kprev = m_k2; m_k2 = m_k1; m_k1 = key0;
            m_s2 = m_s1; m_s1 = sw; m_on = 1'b1;
        end
        #1;
    endtask

    task automatic idle_bus(input int n);
        sw = 10'h000;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        key1 = 1'b0; key0 = 1'b1; sw = 10'h3FF;
        repeat (2) tick();
        total++;
        if (ledr !== 10'h000) begin bad++; $display("FAIL reset_hold: got %h want %h", ledr, 10'h000); end
        key1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (ledr !== exp_led()) begin bad++; $display("FAIL reset_release c%0d: got %h want %h", i, ledr, exp_led()); end
        end
        total++;
        if (ledr[9:8] !== 2'b01 || ledr[3:0] !== 4'hF)
            begin bad++; $display("FAIL reset_first_grant: got %h want grantA data F", ledr); end
    endtask

    task automatic test_single_req();
        idle_bus(4);
        sw = 10'h2A5;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (ledr !== exp_led()) begin bad++; $display("FAIL single_on c%0d: got %h want %h", i, ledr, exp_led()); end
        end
        total++;
        if (ledr[9:8] !== 2'b10 || ledr[3:0] !== 4'hA)
            begin bad++; $display("FAIL single_grant: got %h want grantB data A", ledr); end
        sw = 10'h0A5;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (ledr !== exp_led()) begin bad++; $display("FAIL single_off c%0d: got %h want %h", i, ledr, exp_led()); end
        end
        total++;
        if (ledr[9:8] !== 2'b00 || ledr[3:0] !== 4'h0 || ledr[4] !== 1'b1)
            begin bad++; $display("FAIL single_idle: got %h want idle ptr 1", ledr); end
    endtask

    task automatic test_rotation();
        logic a_turn;
        idle_bus(4);
        sw = 10'h3C3;
        repeat (3) tick();
        for (int i = 0; i < 12; i++) begin
            a_turn = ((i / HOLD) % 2) == 0;
            total++;
            if (ledr[8] !== a_turn || ledr[9] !== !a_turn || ledr[3:0] !== (a_turn ? 4'h3 : 4'hC))
                begin bad++; $display("FAIL rotation c%0d: got %h want %s", i, ledr, a_turn ? "A/3" : "B/C"); end
            total++;
            if (ledr !== exp_led()) begin bad++; $display("FAIL rotation_model c%0d: got %h want %h", i, ledr, exp_led()); end
            tick();
        end
    endtask

    task automatic test_sole();
        idle_bus(4);
        sw = 10'h105;
        repeat (3) tick();
        for (int i = 0; i < 20; i++) begin
            total++;
            if (ledr[9:8] !== 2'b01 || ledr[3:0] !== 4'h5)
                begin bad++; $display("FAIL sole c%0d: got %h want grantA data 5", i, ledr); end
            total++;
            if (ledr !== exp_led()) begin bad++; $display("FAIL sole_model c%0d: got %h want %h", i, ledr, exp_led()); end
            tick();
        end
    endtask

    task automatic test_preempt();
        idle_bus(4);
        sw = 10'h1C3;
        tick();
        sw = 10'h3C3;
        tick();
        key0 = 1'b0;
        for (int e = 3; e <= 8; e++) begin
            tick();
            total++;
            if (ledr !== exp_led()) begin bad++; $display("FAIL preempt_model e%0d: got %h want %h", e, ledr, exp_led()); end
            total++;
            if (e <= 4 && ledr[9:8] !== 2'b01)
                begin bad++; $display("FAIL preempt_hold e%0d: got %h want grantA", e, ledr); end
            else if (e >= 5 && (ledr[9:8] !== 2'b10 || ledr[3:0] !== 4'hC))
                begin bad++; $display("FAIL preempt_switch e%0d: got %h want grantB data C", e, ledr); end
        end
        key0 = 1'b1;
    endtask

    task automatic test_reset_mid_and_conflict();
        idle_bus(4);
        sw = 10'h105;
        repeat (4) tick();
        idle_bus(4);
        sw = 10'h2A5;
        repeat (4) tick();
        total++;
        if (ledr[9:8] !== 2'b10 || ledr[4] !== 1'b0)
            begin bad++; $display("FAIL mid_setup: got %h want grantB ptr 0", ledr); end
        key1 = 1'b0; sw = 10'h000;
        tick();
        total++;
        if (ledr !== 10'h000) begin bad++; $display("FAIL mid_reset: got %h want %h", ledr, 10'h000); end
        key1 = 1'b1;
        tick();
        total++;
        if (ledr !== 10'h010) begin bad++; $display("FAIL mid_release: got %h want %h", ledr, 10'h010); end
        sw = 10'h105;
        for (int e = 1; e <= 8; e++) begin
            if (e == 5) sw = 10'h2C5;
            tick();
            total++;
            if (ledr !== exp_led()) begin bad++; $display("FAIL conflict_model e%0d: got %h want %h", e, ledr, exp_led()); end
            if (e == 7) begin
                total++;
                if (ledr[9:8] !== 2'b00 || ledr[4] !== 1'b0)
                    begin bad++; $display("FAIL conflict_drop_wins: got %h want idle ptr 0", ledr); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) sw = 10'($urandom);
            if ($urandom_range(0, 5) == 0) key0 = ~key0;
            key1 = ($urandom_range(0, 80) != 0);
            tick();
            total++;
            if (ledr !== exp_led()) begin bad++; $display("FAIL random c%0d: got %h want %h", i, ledr, exp_led()); end
        end
        key1 = 1'b1; key0 = 1'b1;
    endtask

    initial begin
        key1 = 1'b0; key0 = 1'b1; sw = 10'h000;
        test_reset();
        test_single_req();
        test_rotation();
        test_sole();
        test_preempt();
        test_reset_mid_and_conflict();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
